// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register and taken-branch redirect controller with post-redirect shadow window.
// Optional statistics counters are built when PC_REDIRECT_STATS_EN is defined.
module pc_redirect_ctrl #(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
    parameter int unsigned          FLUSH_CYCLES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                PCSrc,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                stall,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                if_id_flush,
    output logic                id_ex_flush,
    output logic                ex_mem_flush,
    output logic                redirect_busy,
    output logic                align_err,
    output logic [15:0]         taken_count,
    output logic [15:0]         masked_count
);

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } state_t;

    state_t              r_state;
    logic [2:0]          r_shadow_cnt;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_align_err;
    logic                w_accept;
    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic [PC_WIDTH-1:0] w_target_aligned;

    assign w_accept         = PCSrc & (r_state == RUN) & ~reset;
    assign w_pc_plus4       = r_pc + PC_WIDTH'(4);
    assign w_target_aligned = {branch_target[PC_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_state      <= RUN;
            r_shadow_cnt <= 3'd0;
            r_align_err  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_accept) begin
                        r_pc         <= w_target_aligned;
                        r_shadow_cnt <= 3'(FLUSH_CYCLES);
                        r_state      <= SHADOW;
                        if (branch_target[1:0] != 2'b00) begin
                            r_align_err <= 1'b1;
                        end
                    end else if (!stall) begin
                        r_pc <= w_pc_plus4;
                    end
                end
                SHADOW: begin
                    // The window drains on wall-clock cycles, independent of stall.
                    if (!stall) begin
                        r_pc <= w_pc_plus4;
                    end
                    r_shadow_cnt <= r_shadow_cnt - 3'd1;
                    if (r_shadow_cnt == 3'd1) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef PC_REDIRECT_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_taken_count;
    logic [15:0] r_masked_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_taken_count  <= 16'h0000;
            r_masked_count <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_taken_count <= sat_inc16(r_taken_count);
            end
            if (PCSrc && (r_state == SHADOW)) begin
                r_masked_count <= sat_inc16(r_masked_count);
            end
        end
    end

    assign taken_count  = r_taken_count;
    assign masked_count = r_masked_count;
`else
    assign taken_count  = 16'h0000;
    assign masked_count = 16'h0000;
`endif

    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign if_id_flush   = w_accept;
    assign id_ex_flush   = w_accept;
    assign ex_mem_flush  = w_accept;
    assign redirect_busy = (r_state == SHADOW);
    assign align_err     = r_align_err;

endmodule
